// File: rtl/mt_maint_loop_seq_if.sv
// Maintenance-register side of the MT wraparound sequencer: register fields in,
// loop result and sticky status out.
interface mt_maint_loop_seq_if;
    logic       mrMM;
    logic [3:0] mrMOP;
    logic       mrWRITE;
    logic       mrBPICLK;
    logic [7:0] mrDATA;
    logic [8:0] mtMDF;
    logic       mtBUSY;
    logic       mtDONE;
    logic       mtPERR;
    logic       mtILLOP;
    logic       mtTMO;

    modport master (
        output mrMM, mrMOP, mrWRITE, mrBPICLK, mrDATA,
        input  mtMDF, mtBUSY, mtDONE, mtPERR, mtILLOP, mtTMO
    );

    modport slave (
        input  mrMM, mrMOP, mrWRITE, mrBPICLK, mrDATA,
        output mtMDF, mtBUSY, mtDONE, mtPERR, mtILLOP, mtTMO
    );
endinterface

// File: rtl/mt_maint_loop_seq.sv
// MT maintenance-mode wraparound sequencer: loops one parity-protected character
// through the internal path on BPI clock edges. Optional BPI watchdog: MT_MAINT_TMO_EN.
module mt_maint_loop_seq #(
    parameter int NBITS    = 9,
    parameter int TMO_CLKS = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    mt_maint_loop_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAST = 4'(NBITS - 1);

    if (TMO_CLKS < 1 || TMO_CLKS > 65535) begin : g_bad_tmo
        $error("TMO_CLKS must fit the 16-bit watchdog");
    end

    state_t           state_q, state_d;
    logic [NBITS-1:0] tx_q, tx_d;
    logic [NBITS-1:0] rx_q, rx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [8:0]       mdf_q, mdf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             perr_q, perr_d;
    logic             illop_q, illop_d;
    logic             bpi_q;
    logic             bpi_rise;
`ifdef MT_MAINT_TMO_EN
    logic [15:0]      wdog_q, wdog_d;
    logic             tmo_q, tmo_d;
`endif

    // Odd parity in the top bit; LOOPBAD inverts it to provoke a parity error.
    function automatic logic [NBITS-1:0] make_char(input logic [7:0] d, input logic bad);
        return NBITS'({(~^d) ^ bad, d});
    endfunction

    assign bpi_rise = bus.mrBPICLK & ~bpi_q;

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        mdf_d   = mdf_q;
        busy_d  = busy_q;
        done_d  = done_q;
        perr_d  = perr_q;
        illop_d = illop_q;
`ifdef MT_MAINT_TMO_EN
        wdog_d  = wdog_q;
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.mrWRITE && bus.mrMM) begin
                    done_d  = 1'b0;
                    perr_d  = 1'b0;
                    illop_d = 1'b0;
                    cnt_d   = 4'd0;
`ifdef MT_MAINT_TMO_EN
                    tmo_d   = 1'b0;
                    wdog_d  = 16'(TMO_CLKS);
`endif
                    case (bus.mrMOP)
                        4'd0: done_d = 1'b1;
                        4'd1, 4'd2: begin
                            tx_d    = make_char(bus.mrDATA, bus.mrMOP == 4'd2);
                            rx_d    = '0;
                            busy_d  = 1'b1;
                            state_d = ARM;
                        end
                        default: begin
                            illop_d = 1'b1;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end
            ARM, SHIFT: begin
                // Dropping maintenance mode abandons the character silently.
                if (!bus.mrMM) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (bpi_rise) begin
                    tx_d = tx_q >> 1;
                    rx_d = {tx_q[0], rx_q[NBITS-1:1]};
`ifdef MT_MAINT_TMO_EN
                    wdog_d = 16'(TMO_CLKS);
`endif
                    if (state_q == ARM) begin
                        cnt_d   = 4'd1;
                        state_d = (LAST == 4'd0) ? DONE : SHIFT;
                    end else if (cnt_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
`ifdef MT_MAINT_TMO_EN
                else if (wdog_q == 16'd0) begin
                    tmo_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q - 16'd1;
                end
`endif
            end
            DONE: begin
                mdf_d   = 9'(rx_q);
                perr_d  = ~(^rx_q);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            cnt_q   <= 4'd0;
            mdf_q   <= 9'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            illop_q <= 1'b0;
            bpi_q   <= 1'b0;
`ifdef MT_MAINT_TMO_EN
            wdog_q  <= 16'd0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            mdf_q   <= mdf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
            illop_q <= illop_d;
            bpi_q   <= bus.mrBPICLK;
`ifdef MT_MAINT_TMO_EN
            wdog_q  <= wdog_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign bus.mtMDF   = mdf_q;
    assign bus.mtBUSY  = busy_q;
    assign bus.mtDONE  = done_q;
    assign bus.mtPERR  = perr_q;
    assign bus.mtILLOP = illop_q;
`ifdef MT_MAINT_TMO_EN
    assign bus.mtTMO   = tmo_q;
`else
    assign bus.mtTMO   = 1'b0;
`endif

endmodule

// File: tb/tb_mt_maint_loop_seq.sv
// Directed bench for mt_maint_loop_seq: loop, bad parity, illegal opcode, ignored
// writes, abort, reset mid-shift and BPI stall.
module tb_mt_maint_loop_seq;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    mt_maint_loop_seq_if bus ();

    mt_maint_loop_seq #(.NBITS(9), .TMO_CLKS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Rising edge seen at the next posedge; two low cycles let it be re-armed.
    task automatic bpi_rises(input int n);
        for (int i = 0; i < n; i++) begin
            bus.mrBPICLK = 1'b1;
            tick(2);
            bus.mrBPICLK = 1'b0;
            tick(2);
        end
    endtask

    task automatic start(input logic [3:0] mop, input logic [7:0] data);
        bus.mrMOP   = mop;
        bus.mrDATA  = data;
        bus.mrWRITE = 1'b1;
        tick();
        bus.mrWRITE = 1'b0;
    endtask

    task automatic chk_all0(input string tag);
        chk({tag, "_mdf"},   bus.mtMDF, 9'h000);
        chk({tag, "_busy"},  9'(bus.mtBUSY),  9'd0);
        chk({tag, "_done"},  9'(bus.mtDONE),  9'd0);
        chk({tag, "_perr"},  9'(bus.mtPERR),  9'd0);
        chk({tag, "_illop"}, 9'(bus.mtILLOP), 9'd0);
        chk({tag, "_tmo"},   9'(bus.mtTMO),   9'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.mrMM     = 1'b0;
        bus.mrMOP    = 4'd0;
        bus.mrWRITE  = 1'b0;
        bus.mrBPICLK = 1'b0;
        bus.mrDATA   = 8'h00;
        tick(3);
        rst = 1'b0;
        tick();
        chk_all0("reset");

        // LOOP 5A: odd parity bit set -> 15A
        bus.mrMM = 1'b1;
        start(4'd1, 8'h5A);
        chk("loop1_busy", 9'(bus.mtBUSY), 9'd1);
        bpi_rises(8);
        chk("loop1_8_done", 9'(bus.mtDONE), 9'd0);
        chk("loop1_8_busy", 9'(bus.mtBUSY), 9'd1);
        bpi_rises(1);
        chk("loop1_mdf",  bus.mtMDF, 9'h15A);
        chk("loop1_done", 9'(bus.mtDONE), 9'd1);
        chk("loop1_perr", 9'(bus.mtPERR), 9'd0);
        chk("loop1_busy0", 9'(bus.mtBUSY), 9'd0);

        // LOOPBAD 5A with a BPI rise coinciding with the accept (must not count)
        bus.mrBPICLK = 1'b1;
        start(4'd2, 8'h5A);
        chk("bad_done_clr", 9'(bus.mtDONE), 9'd0);
        tick();
        bus.mrBPICLK = 1'b0;
        tick();
        bpi_rises(8);
        chk("bad_8_done", 9'(bus.mtDONE), 9'd0);
        bpi_rises(1);
        chk("bad_mdf",  bus.mtMDF, 9'h05A);
        chk("bad_perr", 9'(bus.mtPERR), 9'd1);
        chk("bad_done", 9'(bus.mtDONE), 9'd1);

        // LOOP 01 -> parity bit clear
        start(4'd1, 8'h01);
        bpi_rises(9);
        chk("l01_mdf",  bus.mtMDF, 9'h001);
        chk("l01_perr", 9'(bus.mtPERR), 9'd0);
        chk("l01_done", 9'(bus.mtDONE), 9'd1);

        // Same write with MM=0 is ignored entirely
        bus.mrMM = 1'b0;
        start(4'd1, 8'hC3);
        chk("mm0_busy", 9'(bus.mtBUSY), 9'd0);
        bpi_rises(9);
        chk("mm0_mdf",  bus.mtMDF, 9'h001);
        chk("mm0_busy2", 9'(bus.mtBUSY), 9'd0);
        chk("mm0_done", 9'(bus.mtDONE), 9'd1);

        // Illegal opcode, then NOP clears ILLOP
        bus.mrMM = 1'b1;
        start(4'd7, 8'h00);
        chk("ill_illop", 9'(bus.mtILLOP), 9'd1);
        chk("ill_done",  9'(bus.mtDONE), 9'd1);
        chk("ill_busy",  9'(bus.mtBUSY), 9'd0);
        start(4'd0, 8'h00);
        chk("nop_illop", 9'(bus.mtILLOP), 9'd0);
        chk("nop_done",  9'(bus.mtDONE), 9'd1);
        chk("nop_busy",  9'(bus.mtBUSY), 9'd0);

        // Write during a loop is ignored: A5 -> 1A5
        start(4'd1, 8'hA5);
        bpi_rises(4);
        start(4'd2, 8'hFF);
        chk("midw_busy", 9'(bus.mtBUSY), 9'd1);
        bpi_rises(5);
        chk("midw_mdf",  bus.mtMDF, 9'h1A5);
        chk("midw_perr", 9'(bus.mtPERR), 9'd0);
        chk("midw_done", 9'(bus.mtDONE), 9'd1);

        // Abort by dropping MM after 5 edges
        start(4'd1, 8'h3C);
        bpi_rises(5);
        bus.mrMM = 1'b0;
        tick();
        chk("abort_busy", 9'(bus.mtBUSY), 9'd0);
        chk("abort_done", 9'(bus.mtDONE), 9'd0);
        chk("abort_mdf",  bus.mtMDF, 9'h1A5);
        bus.mrMM = 1'b1;
        bpi_rises(9);
        chk("abort_idle_done", 9'(bus.mtDONE), 9'd0);

        // Reset mid-shift
        start(4'd1, 8'h77);
        bpi_rises(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all0("rst_mid");

        // Stalled BPI clock
        start(4'd1, 8'h12);
        tick(30);
`ifdef MT_MAINT_TMO_EN
        chk("stall_tmo",  9'(bus.mtTMO),  9'd1);
        chk("stall_done", 9'(bus.mtDONE), 9'd1);
        chk("stall_busy", 9'(bus.mtBUSY), 9'd0);
        chk("stall_mdf",  bus.mtMDF, 9'h000);
`else
        chk("stall_busy", 9'(bus.mtBUSY), 9'd1);
        chk("stall_tmo",  9'(bus.mtTMO),  9'd0);
        chk("stall_done", 9'(bus.mtDONE), 9'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
